// File: rtl/mbus_arbiter.sv
// Shares one memory bus between instruction-fetch (I) and data (D) masters; tracks data-phase owner, parks orphaned responses.
// Latency: none added; grant is combinational from requests, address passes straight through to the slave.
// Backpressure: s_hready=0 freezes grant/owner; a master that loses the slot sees hready=0 until it is granted.
module mbus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_hsize,
    input  logic        i_htrans,
    output logic [31:0] i_hrdata,
    output logic        i_hresp,
    output logic        i_hready,
    input  logic [31:0] d_haddr,
    input  logic [1:0]  d_hsize,
    input  logic        d_hwrite,
    input  logic [31:0] d_hwdata,
    input  logic        d_htrans,
    output logic [31:0] d_hrdata,
    output logic        d_hresp,
    output logic        d_hready,
    output logic [31:0] s_haddr,
    output logic        s_hprot,
    output logic [1:0]  s_hsize,
    output logic        s_hwrite,
    output logic [31:0] s_hwdata,
    output logic        s_htrans,
    input  logic [31:0] s_hrdata,
    input  logic        s_hresp,
    input  logic        s_hready
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        MST_NONE = 2'd0,
        MST_I    = 2'd1,
        MST_D    = 2'd2
    } mst_e;

    // Per-master response view: hready, capture strobe for the park buffer, and routed data.
    typedef struct packed {
        logic        rdy;
        logic        cap;
        logic        resp;
        logic [31:0] dat;
    } rsp_t;

    mst_e          agnt_q, agnt_d;
    mst_e          owner_q, owner_d;
    mst_e          gnt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bufv_i_q, bufv_i_d, bufv_d_q, bufv_d_d;
    logic [31:0]   rbuf_i_dat_q, rbuf_i_dat_d, rbuf_d_dat_q, rbuf_d_dat_d;
    logic          rbuf_i_resp_q, rbuf_i_resp_d, rbuf_d_resp_q, rbuf_d_resp_d;
    rsp_t          i_rsp, d_rsp;

    // Response routing for one master: live slave data if it owns the data phase and is not being
    // pushed aside, capture into the park buffer if it is, replay the park buffer otherwise.
    function automatic rsp_t route(
        input logic        own,
        input logic        req,
        input logic        won,
        input logic        bufv,
        input logic [31:0] bdat,
        input logic        bresp,
        input logic        srdy,
        input logic [31:0] sdat,
        input logic        serr
    );
        rsp_t r;
        r = '0;
        if (own && (!req || won)) begin
            r.rdy  = srdy;
            r.dat  = sdat;
            r.resp = serr;
        end else if (own) begin
            r.cap = srdy;
        end else begin
            r.rdy = !req || (srdy && won);
            if (bufv) begin
                r.dat  = bdat;
                r.resp = bresp;
            end
        end
        return r;
    endfunction

    // Choose the address-phase owner; D wins unless I has waited through STARVE_LIMIT D grants.
    always_comb begin
        gnt = agnt_q;
        if (s_hready) begin
            if (d_htrans && (!i_htrans || (cnt_q < CW'(STARVE_LIMIT)))) begin
                gnt = MST_D;
            end else if (i_htrans) begin
                gnt = MST_I;
            end else begin
                gnt = MST_NONE;
            end
        end
    end

    assign i_rsp = route(owner_q == MST_I, i_htrans, gnt == MST_I, bufv_i_q, rbuf_i_dat_q,
                         rbuf_i_resp_q, s_hready, s_hrdata, s_hresp);
    assign d_rsp = route(owner_q == MST_D, d_htrans, gnt == MST_D, bufv_d_q, rbuf_d_dat_q,
                         rbuf_d_resp_q, s_hready, s_hrdata, s_hresp);

    // Grant/owner advance on slave ready; starvation counter tracks D wins while I waits.
    always_comb begin
        agnt_d  = agnt_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (s_hready) begin
            agnt_d  = gnt;
            owner_d = gnt;
        end
        if (!i_htrans) begin
            cnt_d = '0;
        end else if (s_hready && gnt == MST_I) begin
            cnt_d = '0;
        end else if (s_hready && gnt == MST_D && cnt_q != CW'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Park buffers: fill when an owner's response arrives while it is already queued behind the
    // other master, drain when that master finally sees hready.
    always_comb begin
        bufv_i_d      = bufv_i_q && !i_rsp.rdy;
        rbuf_i_dat_d  = rbuf_i_dat_q;
        rbuf_i_resp_d = rbuf_i_resp_q;
        if (i_rsp.cap) begin
            bufv_i_d      = 1'b1;
            rbuf_i_dat_d  = s_hrdata;
            rbuf_i_resp_d = s_hresp;
        end
        bufv_d_d      = bufv_d_q && !d_rsp.rdy;
        rbuf_d_dat_d  = rbuf_d_dat_q;
        rbuf_d_resp_d = rbuf_d_resp_q;
        if (d_rsp.cap) begin
            bufv_d_d      = 1'b1;
            rbuf_d_dat_d  = s_hrdata;
            rbuf_d_resp_d = s_hresp;
        end
    end

    // Slave-side mux: address/control follow the grant, write data follows the data-phase owner.
    always_comb begin
        s_htrans = (gnt != MST_NONE);
        s_hprot  = (gnt == MST_D);
        s_haddr  = '0;
        s_hsize  = '0;
        s_hwrite = 1'b0;
        case (gnt)
            MST_D: begin
                s_haddr  = d_haddr;
                s_hsize  = d_hsize;
                s_hwrite = d_hwrite;
            end
            MST_I: begin
                s_haddr = i_haddr;
                s_hsize = i_hsize;
            end
            default: ;
        endcase
        s_hwdata = (owner_q == MST_D) ? d_hwdata : 32'd0;
        i_hready = i_rsp.rdy;
        i_hrdata = i_rsp.dat;
        i_hresp  = i_rsp.resp;
        d_hready = d_rsp.rdy;
        d_hrdata = d_rsp.dat;
        d_hresp  = d_rsp.resp;
    end

    // State registers; reset abandons any in-flight transfer without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agnt_q        <= MST_NONE;
            owner_q       <= MST_NONE;
            cnt_q         <= '0;
            bufv_i_q      <= 1'b0;
            bufv_d_q      <= 1'b0;
            rbuf_i_dat_q  <= '0;
            rbuf_i_resp_q <= 1'b0;
            rbuf_d_dat_q  <= '0;
            rbuf_d_resp_q <= 1'b0;
        end else begin
            agnt_q        <= agnt_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            bufv_i_q      <= bufv_i_d;
            bufv_d_q      <= bufv_d_d;
            rbuf_i_dat_q  <= rbuf_i_dat_d;
            rbuf_i_resp_q <= rbuf_i_resp_d;
            rbuf_d_dat_q  <= rbuf_d_dat_d;
            rbuf_d_resp_q <= rbuf_d_resp_d;
        end
    end

    // A master cannot both own the live data phase and hold a parked response.
    a_own_buf_i: assert property (@(posedge clk) disable iff (rst) !(owner_q == MST_I && bufv_i_q));
    a_own_buf_d: assert property (@(posedge clk) disable iff (rst) !(owner_q == MST_D && bufv_d_q));

endmodule

// File: tb/tb_mbus_arbiter.sv
// Bench for mbus_arbiter: directed scenarios plus random traffic against a queue-based reference model.
// Latency: outputs compared mid-cycle every cycle against the model.
// Backpressure: random s_hready stalls; masters hold requests until their hready is seen.
module tb_mbus_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_haddr;
    logic [1:0]  i_hsize;
    logic        i_htrans;
    logic [31:0] i_hrdata;
    logic        i_hresp;
    logic        i_hready;
    logic [31:0] d_haddr;
    logic [1:0]  d_hsize;
    logic        d_hwrite;
    logic [31:0] d_hwdata;
    logic        d_htrans;
    logic [31:0] d_hrdata;
    logic        d_hresp;
    logic        d_hready;
    logic [31:0] s_haddr;
    logic        s_hprot;
    logic [1:0]  s_hsize;
    logic        s_hwrite;
    logic [31:0] s_hwdata;
    logic        s_htrans;
    logic [31:0] s_hrdata;
    logic        s_hresp;
    logic        s_hready;

    always #5 clk = ~clk;

    mbus_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_haddr(i_haddr), .i_hsize(i_hsize), .i_htrans(i_htrans),
        .i_hrdata(i_hrdata), .i_hresp(i_hresp), .i_hready(i_hready),
        .d_haddr(d_haddr), .d_hsize(d_hsize), .d_hwrite(d_hwrite), .d_hwdata(d_hwdata),
        .d_htrans(d_htrans), .d_hrdata(d_hrdata), .d_hresp(d_hresp), .d_hready(d_hready),
        .s_haddr(s_haddr), .s_hprot(s_hprot), .s_hsize(s_hsize), .s_hwrite(s_hwrite),
        .s_hwdata(s_hwdata), .s_htrans(s_htrans), .s_hrdata(s_hrdata), .s_hresp(s_hresp),
        .s_hready(s_hready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Masters: 0 = nobody, 1 = I, 2 = D.
    int          m_inflight = 0;   // master whose transfer is in its data phase
    int          m_bus      = 0;   // master the bus sits on while the slave stalls
    int          m_streak   = 0;   // consecutive D wins while I was waiting
    logic [32:0] park_i[$];        // undelivered {resp,data} for I
    logic [32:0] park_d[$];
    int          e_win;
    logic        e_i_rdy, e_d_rdy;
    logic [32:0] e_i_rsp, e_d_rsp;
    bit          e_i_care, e_d_care, e_i_cap, e_d_cap, e_i_pop, e_d_pop;

    task automatic model_reset();
        m_inflight = 0;
        m_bus      = 0;
        m_streak   = 0;
        park_i.delete();
        park_d.delete();
    endtask

    task automatic side(input int me, input logic req, input bit has_park, input logic [32:0] park_val,
                        output logic rdy, output logic [32:0] rsp, output bit care,
                        output bit cap, output bit pop);
        rdy  = !req || (s_hready && e_win == me);
        rsp  = '0;
        care = 1'b1;
        cap  = 1'b0;
        pop  = 1'b0;
        if (m_inflight == me) begin
            if (!req || e_win == me) begin
                rdy = s_hready;
                rsp = {s_hresp, s_hrdata};
            end else begin
                rdy  = 1'b0;
                care = 1'b0;
                cap  = s_hready;
            end
        end else if (has_park) begin
            rsp = park_val;
            pop = rdy;
        end
    endtask

    task automatic model_eval();
        if (rst) model_reset();
        if (!s_hready)                                   e_win = m_bus;
        else if (d_htrans && (!i_htrans || m_streak < LIM)) e_win = 2;
        else if (i_htrans)                               e_win = 1;
        else                                             e_win = 0;
        side(1, i_htrans, park_i.size() != 0, (park_i.size() != 0) ? park_i[0] : 33'd0,
             e_i_rdy, e_i_rsp, e_i_care, e_i_cap, e_i_pop);
        side(2, d_htrans, park_d.size() != 0, (park_d.size() != 0) ? park_d[0] : 33'd0,
             e_d_rdy, e_d_rsp, e_d_care, e_d_cap, e_d_pop);
    endtask

    task automatic model_advance();
        if (rst) begin
            model_reset();
            return;
        end
        if (e_i_pop) void'(park_i.pop_front());
        if (e_d_pop) void'(park_d.pop_front());
        if (e_i_cap) park_i.push_back({s_hresp, s_hrdata});
        if (e_d_cap) park_d.push_back({s_hresp, s_hrdata});
        if (!i_htrans)                                       m_streak = 0;
        else if (s_hready && e_win == 1)                     m_streak = 0;
        else if (s_hready && e_win == 2 && m_streak < LIM)   m_streak = m_streak + 1;
        if (s_hready) begin
            m_inflight = e_win;
            m_bus      = e_win;
        end
    endtask

    task automatic compare_all();
        check_eq("s_htrans", 32'(s_htrans), 32'(e_win != 0));
        check_eq("s_hprot",  32'(s_hprot),  32'(e_win == 2));
        check_eq("s_haddr",  s_haddr, (e_win == 2) ? d_haddr : (e_win == 1) ? i_haddr : 32'd0);
        check_eq("s_hsize",  32'(s_hsize), (e_win == 2) ? 32'(d_hsize) : (e_win == 1) ? 32'(i_hsize) : 32'd0);
        check_eq("s_hwrite", 32'(s_hwrite), 32'(e_win == 2 && d_hwrite));
        check_eq("s_hwdata", s_hwdata, (m_inflight == 2) ? d_hwdata : 32'd0);
        check_eq("i_hready", 32'(i_hready), 32'(e_i_rdy));
        check_eq("d_hready", 32'(d_hready), 32'(e_d_rdy));
        if (e_i_care) begin
            check_eq("i_hrdata", i_hrdata, e_i_rsp[31:0]);
            check_eq("i_hresp", 32'(i_hresp), 32'(e_i_rsp[32]));
        end
        if (e_d_care) begin
            check_eq("d_hrdata", d_hrdata, e_d_rsp[31:0]);
            check_eq("d_hresp", 32'(d_hresp), 32'(e_d_rsp[32]));
        end
    endtask

    // Inputs are applied 1 unit after the rising edge; compare 3 units later, well before the falling edge.
    task automatic settle();
        #3;
        model_eval();
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        i_haddr = '0; i_hsize = '0; i_htrans = 1'b0;
        d_haddr = '0; d_hsize = '0; d_hwrite = 1'b0; d_hwdata = '0; d_htrans = 1'b0;
        s_hrdata = '0; s_hresp = 1'b0; s_hready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset state
        settle();
        check_eq("rst_i_hready", 32'(i_hready), 32'd1);
        check_eq("rst_d_hready", 32'(d_hready), 32'd1);
        check_eq("rst_s_htrans", 32'(s_htrans), 32'd0);
        check_eq("rst_i_hrdata", i_hrdata, 32'd0);
        check_eq("rst_d_hrdata", d_hrdata, 32'd0);
        check_eq("rst_d_hresp", 32'(d_hresp), 32'd0);
        advance();
        rst = 1'b0;

        // Fetch-only back-to-back stream
        for (int k = 0; k < 6; k++) begin
            i_htrans = 1'b1;
            i_hsize  = 2'b01;
            i_haddr  = 32'(32'h1000 + 4 * k);
            s_hrdata = (k == 0) ? 32'd0 : 32'(32'h1100 + 4 * (k - 1));
            settle();
            check_eq("t1_htrans", 32'(s_htrans), 32'd1);
            check_eq("t1_hprot", 32'(s_hprot), 32'd0);
            check_eq("t1_i_hready", 32'(i_hready), 32'd1);
            if (k > 0) check_eq("t1_i_hrdata", i_hrdata, 32'(32'h1100 + 4 * (k - 1)));
            advance();
        end
        idle_inputs();
        settle();
        advance();

        // Simultaneous request from idle: D first, then I
        i_htrans = 1'b1; i_haddr = 32'h100;
        d_htrans = 1'b1; d_haddr = 32'h2000;
        settle();
        check_eq("t2_haddr_d", s_haddr, 32'h2000);
        check_eq("t2_hprot_d", 32'(s_hprot), 32'd1);
        check_eq("t2_i_hready", 32'(i_hready), 32'd0);
        advance();
        d_htrans = 1'b0;
        settle();
        check_eq("t2_haddr_i", s_haddr, 32'h100);
        check_eq("t2_hprot_i", 32'(s_hprot), 32'd0);
        advance();
        idle_inputs();
        settle();
        advance();

        // Starvation limit: both held, I gets every fifth slot
        i_htrans = 1'b1; i_haddr = 32'h140;
        d_htrans = 1'b1; d_haddr = 32'h2400;
        for (int k = 0; k < 10; k++) begin
            s_hrdata = 32'(32'hA000 + k);
            settle();
            check_eq("t3_grant_is_d", 32'(s_hprot), 32'((k % 5) != 4));
            advance();
        end
        idle_inputs();
        settle();
        advance();
        settle();
        advance();

        // Parked fetch response
        i_htrans = 1'b1; i_haddr = 32'h400;
        settle();
        advance();
        i_haddr  = 32'h404;
        d_htrans = 1'b1; d_haddr = 32'h2100;
        s_hrdata = 32'h12345678;
        settle();
        check_eq("t4_i_hready_lost", 32'(i_hready), 32'd0);
        check_eq("t4_hprot", 32'(s_hprot), 32'd1);
        advance();
        d_htrans = 1'b0;
        s_hrdata = 32'hDEADBEEF;
        settle();
        check_eq("t4_i_hready_won", 32'(i_hready), 32'd1);
        check_eq("t4_i_hrdata", i_hrdata, 32'h12345678);
        advance();
        idle_inputs();
        settle();
        advance();
        settle();
        advance();

        // Slave stall during D data phase with I pending
        d_htrans = 1'b1; d_haddr = 32'h3000; d_hwrite = 1'b1;
        settle();
        advance();
        d_haddr = 32'h3004; d_hwdata = 32'h55AA55AA;
        i_htrans = 1'b1; i_haddr = 32'h500;
        s_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check_eq("t5_haddr", s_haddr, 32'h3004);
            check_eq("t5_hprot", 32'(s_hprot), 32'd1);
            check_eq("t5_d_hready", 32'(d_hready), 32'd0);
            advance();
        end
        s_hready = 1'b1;
        settle();
        advance();

        // Reset in the middle of a D write data phase, I pending
        d_htrans = 1'b0; d_hwdata = 32'hCAFEF00D;
        s_hready = 1'b0;
        rst = 1'b1;
        settle();
        check_eq("t6_d_hready", 32'(d_hready), 32'd1);
        check_eq("t6_s_hwdata", s_hwdata, 32'd0);
        check_eq("t6_s_htrans", 32'(s_htrans), 32'd0);
        advance();
        rst = 1'b0;
        idle_inputs();
        settle();
        advance();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            int p_i;
            int p_d;
            p_i = (c < 2000) ? 50 : 90;
            p_d = (c < 2000) ? 50 : 85;
            rst = ($urandom_range(0, 299) == 0);
            if (!i_htrans || e_i_rdy) begin
                i_htrans = ($urandom_range(0, 99) < p_i);
                i_haddr  = $urandom;
                i_hsize  = 2'($urandom_range(0, 3));
            end
            if (!d_htrans || e_d_rdy) begin
                d_htrans = ($urandom_range(0, 99) < p_d);
                d_haddr  = $urandom;
                d_hsize  = 2'($urandom_range(0, 3));
                d_hwrite = 1'($urandom_range(0, 1));
            end
            d_hwdata = $urandom;
            s_hready = ($urandom_range(0, 99) < 70);
            s_hrdata = $urandom;
            s_hresp  = ($urandom_range(0, 99) < 10);
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
